// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: 3-digit BCD up/down timer controller feeding a 7-segment decoder.
// Holds a 000-999 count. Start/pause/clear/load commands control it, and it
// steps once on each count-enable tick while running.
//
// Optional build macro: TIMER_PRESCALER_EN
//   When defined, an internal divider produces one tick every CLK_DIV clk
//   cycles while in RUN, and tick_en is ignored.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   tick_en        count-enable pulse (unused with TIMER_PRESCALER_EN)
//   start          level, request RUN
//   pause          level, request PAUSED
//   clear          level, zero count and go IDLE
//   load           level, load load_val (nibbles clamped to 9)
//   load_val[11:0] preset {hundreds,tens,ones}
//   dir            0 = count up, 1 = count down
//   bcd0/1/2[3:0]  ones/tens/hundreds digits (registered)
//   running        high while state is RUN (registered)
//   done           one-cycle terminal-event pulse (registered)
module bcd_timer_ctrl #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_en,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic        dir,
  output logic [3:0]  bcd0,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd2,
  output logic        running,
  output logic        done
);

  localparam int unsigned DIG_W  = 4;
  localparam int unsigned N_DIG  = 3;
  localparam int unsigned CNT_W  = DIG_W * N_DIG;
  localparam int unsigned DIV_W  = 24;

  if (CLK_DIV < 1 || CLK_DIV > 32'd16777216) begin : g_bad_clk_div
    $error("bcd_timer_ctrl: CLK_DIV out of range 1..2^24");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_running;
  logic               r_done;
  logic               w_done_nxt;
  logic               w_run_entry;
  logic               w_run_cycle;
  logic               w_tick;

  // Per-digit BCD increment with carry; 999 wraps to 000.
  function automatic logic [CNT_W-1:0] bcd_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    logic             c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (c) begin
        if (v[i*DIG_W +: DIG_W] == 4'd9) begin
          r[i*DIG_W +: DIG_W] = 4'd0;
        end else begin
          r[i*DIG_W +: DIG_W] = v[i*DIG_W +: DIG_W] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Per-digit BCD decrement with borrow; 000 wraps to 999.
  function automatic logic [CNT_W-1:0] bcd_dec(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    logic             b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (b) begin
        if (v[i*DIG_W +: DIG_W] == 4'd0) begin
          r[i*DIG_W +: DIG_W] = 4'd9;
        end else begin
          r[i*DIG_W +: DIG_W] = v[i*DIG_W +: DIG_W] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Force every nibble into 0..9 so digits never leave BCD range.
  function automatic logic [CNT_W-1:0] bcd_clamp(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    for (int i = 0; i < int'(N_DIG); i++) begin
      r[i*DIG_W +: DIG_W] = (v[i*DIG_W +: DIG_W] > 4'd9) ? 4'd9 : v[i*DIG_W +: DIG_W];
    end
    return r;
  endfunction

`ifdef TIMER_PRESCALER_EN
  logic [DIV_W-1:0] r_div;
  logic             w_div_tick;
  logic             w_unused_tick;

  assign w_unused_tick = tick_en;
  assign w_div_tick    = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_tick        = w_div_tick;

  // Divider restarts on every RUN entry so the first step lands CLK_DIV cycles later.
  always_ff @(posedge clk) begin
    if (rst || clear || w_run_entry) begin
      r_div <= '0;
    end else if (w_run_cycle) begin
      r_div <= w_div_tick ? '0 : r_div + DIV_W'(1);
    end
  end
`else
  assign w_tick = tick_en;
`endif

  // Next-state / next-count with command priority clear > load > pause > start > tick.
  // Commands that are ignored in the current state fall through to lower ones.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_run_entry = 1'b0;
    w_run_cycle = 1'b0;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (load && (r_state != S_RUN)) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = bcd_clamp(load_val);
    end else if (pause) begin
      // pause also swallows a simultaneous start outside RUN
      if (r_state == S_RUN) begin
        w_state_nxt = S_PAUSED;
      end
    end else if (start && ((r_state == S_IDLE) || (r_state == S_PAUSED))) begin
      if (dir && (r_cnt == '0)) begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = S_RUN;
        w_run_entry = 1'b1;
      end
    end else if (r_state == S_RUN) begin
      w_run_cycle = 1'b1;
      if (w_tick) begin
        if (!dir) begin
          w_cnt_nxt  = bcd_inc(r_cnt);
          w_done_nxt = (w_cnt_nxt == '0);
        end else begin
          w_cnt_nxt = bcd_dec(r_cnt);
          if (w_cnt_nxt == '0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_running <= (w_state_nxt == S_RUN);
      r_done    <= w_done_nxt;
    end
  end

  assign bcd0    = r_cnt[3:0];
  assign bcd1    = r_cnt[7:4];
  assign bcd2    = r_cnt[11:8];
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Testbench for bcd_timer_ctrl: directed scenarios plus randomized commands,
// checked every cycle against an integer-count reference model.
module tb_bcd_timer_ctrl;

  localparam int unsigned TB_CLK_DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst, tick_en, start, pause, clear, load, dir;
  logic [11:0] load_val;
  logic [3:0]  bcd0, bcd1, bcd2;
  logic        running, done;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_st  = M_IDLE;
  int m_cnt = 0;
  int m_div = 0;
  bit m_done = 1'b0;
  bit seen_done;

  always #5 clk = ~clk;

  bcd_timer_ctrl #(.CLK_DIV(TB_CLK_DIV)) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .start(start), .pause(pause),
    .clear(clear), .load(load), .load_val(load_val), .dir(dir),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .running(running), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_val(input logic [11:0] v);
    int h, t, o;
    h = int'(v[11:8]); t = int'(v[7:4]); o = int'(v[3:0]);
    if (h > 9) h = 9;
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return h * 100 + t * 10 + o;
  endfunction

  function automatic logic [11:0] to_bcd(input int c);
    return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  // Model of one clock edge from the current inputs.
  task automatic model_step();
    bit tk;
    m_done = 1'b0;
    if (rst) begin
      m_st = M_IDLE; m_cnt = 0; m_div = 0;
    end else if (clear) begin
      m_st = M_IDLE; m_cnt = 0; m_div = 0;
    end else if (load && m_st != M_RUN) begin
      m_st = M_IDLE; m_cnt = clamp_val(load_val);
    end else if (pause) begin
      if (m_st == M_RUN) m_st = M_PAUSED;
    end else if (start && (m_st == M_IDLE || m_st == M_PAUSED)) begin
      if (dir && m_cnt == 0) begin
        m_st = M_DONE; m_done = 1'b1;
      end else begin
        m_st = M_RUN; m_div = 0;
      end
    end else if (m_st == M_RUN) begin
`ifdef TIMER_PRESCALER_EN
      tk = (m_div == int'(TB_CLK_DIV) - 1);
      m_div = tk ? 0 : m_div + 1;
`else
      tk = tick_en;
`endif
      if (tk) begin
        if (!dir) begin
          m_cnt = (m_cnt + 1) % 1000;
          if (m_cnt == 0) m_done = 1'b1;
        end else begin
          m_cnt = (m_cnt + 999) % 1000;
          if (m_cnt == 0) begin
            m_done = 1'b1; m_st = M_DONE;
          end
        end
      end
    end
  endtask

  // Advance one edge and compare all outputs with the model.
  task automatic do_cycle();
    model_step();
    @(posedge clk);
    #1;
    if (done === 1'b1) seen_done = 1'b1;
    check("digits", 32'({bcd2, bcd1, bcd0}), 32'(to_bcd(m_cnt)));
    check("running", 32'(running), 32'(m_st == M_RUN));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic idle_inputs();
    rst = 0; tick_en = 0; start = 0; pause = 0; clear = 0; load = 0;
  endtask

  task automatic cmd_clear();
    idle_inputs(); clear = 1; do_cycle(); idle_inputs();
  endtask

  task automatic cmd_load(input logic [11:0] v);
    idle_inputs(); load = 1; load_val = v; do_cycle(); idle_inputs();
  endtask

  task automatic cmd_start();
    idle_inputs(); start = 1; do_cycle(); idle_inputs();
  endtask

  // n steps: n tick_en cycles, or n full divider periods with the prescaler.
  task automatic run_ticks(input int n);
    idle_inputs();
    tick_en = 1;
`ifdef TIMER_PRESCALER_EN
    repeat (n * int'(TB_CLK_DIV)) do_cycle();
`else
    repeat (n) do_cycle();
`endif
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    dir = 0; load_val = '0; seen_done = 0;
    @(negedge clk);
    rst = 1; do_cycle();
    check("por_digits", 32'({bcd2, bcd1, bcd0}), 32'h0);

    // reset in the middle of a count
    cmd_clear(); cmd_load(12'h345); dir = 0; cmd_start(); run_ticks(2);
    check("pre_rst", 32'({bcd2, bcd1, bcd0}), 32'h347);
    idle_inputs(); rst = 1; tick_en = 1; start = 1;
    repeat (3) do_cycle();
    check("rst_digits", 32'({bcd2, bcd1, bcd0}), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    idle_inputs(); do_cycle();
    check("post_rst_running", 32'(running), 32'h0);

    // count up 5 from 123
    cmd_load(12'h123); dir = 0; cmd_start();
    seen_done = 0; run_ticks(5);
    check("up5_digits", 32'({bcd2, bcd1, bcd0}), 32'h128);
    check("up5_running", 32'(running), 32'h1);
    check("up5_no_done", 32'(seen_done), 32'h0);

    // up wrap 998 -> 999 -> 000 with done pulse
    cmd_clear(); cmd_load(12'h998); dir = 0; cmd_start();
    run_ticks(1);
    check("wrap_999", 32'({bcd2, bcd1, bcd0}), 32'h999);
    run_ticks(1);
    check("wrap_000", 32'({bcd2, bcd1, bcd0}), 32'h0);
    check("wrap_done", 32'(done), 32'h1);
    check("wrap_running", 32'(running), 32'h1);
    idle_inputs(); do_cycle();
    check("wrap_done_1cyc", 32'(done), 32'h0);

    // count down to DONE
    cmd_clear(); cmd_load(12'h002); dir = 1; cmd_start();
    run_ticks(1);
    check("dn_001", 32'({bcd2, bcd1, bcd0}), 32'h001);
    run_ticks(1);
    check("dn_000", 32'({bcd2, bcd1, bcd0}), 32'h0);
    check("dn_done", 32'(done), 32'h1);
    check("dn_running", 32'(running), 32'h0);
    run_ticks(1);
    check("dn_hold", 32'({bcd2, bcd1, bcd0}), 32'h0);
    check("dn_done_low", 32'(done), 32'h0);
    dir = 0; cmd_start();
    check("done_start_ign", 32'(running), 32'h0);
    cmd_clear(); cmd_start();
    check("clear_to_idle", 32'(running), 32'h1);

    // start at 000 counting down goes straight to DONE
    cmd_clear(); dir = 1; cmd_start();
    check("start0_done", 32'(done), 32'h1);
    check("start0_running", 32'(running), 32'h0);

    // pause/start/tick together, load in RUN, clear
    cmd_clear(); cmd_load(12'h050); dir = 0; cmd_start();
    idle_inputs(); pause = 1; start = 1; tick_en = 1; do_cycle(); idle_inputs();
    check("pause_cnt", 32'({bcd2, bcd1, bcd0}), 32'h050);
    check("pause_running", 32'(running), 32'h0);
    cmd_start();
    cmd_load(12'h777);
    check("run_load_ign", 32'({bcd2, bcd1, bcd0}), 32'h050);
    check("run_load_running", 32'(running), 32'h1);
    cmd_clear();
    check("clr_cnt", 32'({bcd2, bcd1, bcd0}), 32'h0);
    check("clr_running", 32'(running), 32'h0);

    // nibble clamp
    cmd_load(12'h1AF);
    check("clamp", 32'({bcd2, bcd1, bcd0}), 32'h199);

`ifdef TIMER_PRESCALER_EN
    // first step exactly CLK_DIV cycles after RUN entry
    cmd_clear(); cmd_load(12'h010); dir = 0; cmd_start();
    idle_inputs(); tick_en = 1;
    repeat (TB_CLK_DIV - 1) do_cycle();
    check("psc_before", 32'({bcd2, bcd1, bcd0}), 32'h010);
    do_cycle();
    check("psc_first", 32'({bcd2, bcd1, bcd0}), 32'h011);
    idle_inputs();
`endif

    // randomized command mix against the model
    for (int i = 0; i < 4000; i++) begin
      idle_inputs();
      rst      = ($urandom_range(0, 199) == 0);
      clear    = ($urandom_range(0, 63) == 0);
      load     = ($urandom_range(0, 23) == 0);
      pause    = ($urandom_range(0, 19) == 0);
      start    = ($urandom_range(0, 7) == 0);
      tick_en  = ($urandom_range(0, 2) != 0);
      dir      = ($urandom_range(0, 3) == 0) ? ~dir : dir;
      load_val = ($urandom_range(0, 3) == 0) ? 12'($urandom) : to_bcd($urandom_range(0, 999));
      do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
